// File: rtl/regfile_mrnw_sync.sv
// regfile_mrnw_sync: clocked multi-read/multi-write register file with collision flag, bypass and post-reset clear
module regfile_mrnw_sync #(
  parameter int WIDTH      = 24,
  parameter int DEPTH      = 64,
  parameter int RD_PORTS   = 4,
  parameter int WR_PORTS   = 2,
  parameter int BYPASS     = 1,
  parameter int INIT_CLEAR = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      busy,
  input  logic [RD_PORTS-1:0]       rd_en,
  input  logic [RD_PORTS*AW-1:0]    rd_adr,
  output logic [RD_PORTS*WIDTH-1:0] rd_dat,
  input  logic [WR_PORTS-1:0]       wr_en,
  input  logic [WR_PORTS*AW-1:0]    wr_adr,
  input  logic [WR_PORTS*WIDTH-1:0] wr_dat,
  output logic                      wr_collision
);
  typedef enum logic {INIT, READY} state_e;
  state_e                     state_q;
  logic [AW-1:0]              cnt_q;
  logic [WIDTH-1:0]           mem_q [DEPTH];
  logic [RD_PORTS*WIDTH-1:0]  rd_dat_q, rd_dat_d;
  logic                       coll_q, coll_d;
  logic                       ready;
  assign ready        = state_q == READY;
  assign busy         = ~ready;
  assign rd_dat       = rd_dat_q;
  assign wr_collision = coll_q;
  // later write ports override earlier ones, so the highest-numbered match is forwarded
  always_comb begin
    rd_dat_d = rd_dat_q;
    coll_d   = 1'b0;
    for (int i = 0; i < WR_PORTS; i++)
      for (int j = i + 1; j < WR_PORTS; j++)
        if (ready && wr_en[i] && wr_en[j] && wr_adr[i*AW +: AW] == wr_adr[j*AW +: AW]) coll_d = 1'b1;
    for (int p = 0; p < RD_PORTS; p++)
      if (ready && rd_en[p]) begin
        rd_dat_d[p*WIDTH +: WIDTH] = mem_q[rd_adr[p*AW +: AW]];
        for (int w = 0; w < WR_PORTS; w++)
          if (BYPASS != 0 && wr_en[w] && wr_adr[w*AW +: AW] == rd_adr[p*AW +: AW])
            rd_dat_d[p*WIDTH +: WIDTH] = wr_dat[w*WIDTH +: WIDTH];
      end
  end
  always_ff @(posedge clk)
    if (!reset) begin
      if (!ready) mem_q[cnt_q] <= '0;
      else
        for (int w = 0; w < WR_PORTS; w++)
          if (wr_en[w]) mem_q[wr_adr[w*AW +: AW]] <= wr_dat[w*WIDTH +: WIDTH];
    end
  always_ff @(posedge clk)
    if (reset) begin
      state_q  <= (INIT_CLEAR != 0) ? INIT : READY;
      cnt_q    <= '0;
      rd_dat_q <= '0;
      coll_q   <= 1'b0;
    end else begin
      if (!ready) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == {AW{1'b1}}) state_q <= READY;
      end
      rd_dat_q <= rd_dat_d;
      coll_q   <= coll_d;
    end
endmodule

// File: tb/tb_regfile_mrnw_sync.sv
// tb_regfile_mrnw_sync: scoreboard bench for the register file, bypass on/off plus a small-parameter instance
module tb_regfile_mrnw_sync;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset;
  logic [3:0]  rd_en;
  logic [23:0] rd_adr;
  logic [1:0]  wr_en;
  logic [11:0] wr_adr;
  logic [47:0] wr_dat;
  logic        busy_a, busy_b, coll_a, coll_b;
  logic [95:0] rd_a, rd_b;
  logic        s_reset, s_rd_en, s_wr_en, s_busy, s_coll;
  logic [1:0]  s_rd_adr, s_wr_adr;
  logic [7:0]  s_wr_dat, s_rd_dat;

  regfile_mrnw_sync dut_a (
    .clk(clk), .reset(reset), .busy(busy_a),
    .rd_en(rd_en), .rd_adr(rd_adr), .rd_dat(rd_a),
    .wr_en(wr_en), .wr_adr(wr_adr), .wr_dat(wr_dat), .wr_collision(coll_a));
  regfile_mrnw_sync #(.BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .busy(busy_b),
    .rd_en(rd_en), .rd_adr(rd_adr), .rd_dat(rd_b),
    .wr_en(wr_en), .wr_adr(wr_adr), .wr_dat(wr_dat), .wr_collision(coll_b));
  regfile_mrnw_sync #(.WIDTH(8), .DEPTH(4), .RD_PORTS(1), .WR_PORTS(1), .INIT_CLEAR(0)) dut_s (
    .clk(clk), .reset(s_reset), .busy(s_busy),
    .rd_en(s_rd_en), .rd_adr(s_rd_adr), .rd_dat(s_rd_dat),
    .wr_en(s_wr_en), .wr_adr(s_wr_adr), .wr_dat(s_wr_dat), .wr_collision(s_coll));

  typedef struct {
    logic        busy;
    logic        coll;
    logic [95:0] rda;
    logic [95:0] rdb;
    logic [7:0]  rds;
  } exp_t;
  exp_t sbq[$];
  int n_vec = 0, n_miss = 0;

  logic [23:0] mm [64];
  logic [23:0] ea [4];
  logic [23:0] eb [4];
  logic        ec = 1'b0;
  int          bl = 0;
  logic [7:0]  sm [4];
  logic [7:0]  es = 8'h0;
  int          sc = 0;

  function automatic logic [23:0] wd(int w); return wr_dat[w*24 +: 24]; endfunction
  function automatic logic [5:0]  wa(int w); return wr_adr[w*6 +: 6];   endfunction
  function automatic logic [5:0]  ra(int p); return rd_adr[p*6 +: 6];   endfunction

  function automatic logic [5:0] pick();
    int k = $urandom_range(0, 3);
    return k == 0 ? 6'd0 : k == 1 ? 6'd63 : k == 2 ? 6'($urandom_range(0, 7)) : 6'($urandom);
  endfunction

  task automatic sweep_drive();
    s_reset = sc == 0; s_rd_en = 1'b0; s_wr_en = 1'b0;
    s_rd_adr = 2'd0; s_wr_adr = 2'd0; s_wr_dat = 8'h0;
    if (sc == 1) begin s_wr_en = 1'b1; s_wr_adr = 2'd0; s_wr_dat = 8'h5A; end
    else if (sc == 2) begin s_wr_en = 1'b1; s_wr_adr = 2'd3; s_wr_dat = 8'hA5; end
    else if (sc == 3) begin s_wr_en = 1'b1; s_wr_adr = 2'd1; s_wr_dat = 8'($urandom); end
    else if (sc == 4) begin s_wr_en = 1'b1; s_wr_adr = 2'd2; s_wr_dat = 8'($urandom); s_rd_en = 1'b1; s_rd_adr = 2'd0; end
    else if (sc == 5) begin s_rd_en = 1'b1; s_rd_adr = 2'd3; end
    else if (sc > 5) begin
      s_wr_en = 1'($urandom); s_wr_adr = 2'($urandom); s_wr_dat = 8'($urandom);
      s_rd_en = 1'($urandom); s_rd_adr = 2'($urandom);
    end
    sc++;
  endtask

  task automatic step();
    exp_t e;
    logic [23:0] v;
    sweep_drive();
    if (reset) begin
      bl = 64; ec = 1'b0;
      foreach (mm[i]) mm[i] = 24'h0;
      for (int p = 0; p < 4; p++) begin ea[p] = 24'h0; eb[p] = 24'h0; end
    end else if (bl > 0) begin
      bl--; ec = 1'b0;
    end else begin
      for (int p = 0; p < 4; p++)
        if (rd_en[p]) begin
          v = mm[ra(p)];
          eb[p] = v;
          if (wr_en[1] && wa(1) == ra(p)) v = wd(1);
          else if (wr_en[0] && wa(0) == ra(p)) v = wd(0);
          ea[p] = v;
        end
      ec = (&wr_en) && wa(0) == wa(1);
      if (wr_en[0]) mm[wa(0)] = wd(0);
      if (wr_en[1]) mm[wa(1)] = wd(1);
    end
    if (s_reset) es = 8'h0;
    else begin
      if (s_rd_en) es = (s_wr_en && s_wr_adr == s_rd_adr) ? s_wr_dat : sm[s_rd_adr];
      if (s_wr_en) sm[s_wr_adr] = s_wr_dat;
    end
    e.busy = bl > 0; e.coll = ec; e.rds = es;
    e.rda = {ea[3], ea[2], ea[1], ea[0]};
    e.rdb = {eb[3], eb[2], eb[1], eb[0]};
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 1'b0; rd_en = 4'h0; wr_en = 2'b00;
  endtask

  task automatic rnd();
    reset = 1'b0;
    rd_en = 4'($urandom); wr_en = 2'($urandom);
    for (int p = 0; p < 4; p++) rd_adr[p*6 +: 6] = pick();
    for (int w = 0; w < 2; w++) wr_adr[w*6 +: 6] = pick();
    wr_dat = 48'({$urandom(), $urandom()});
  endtask

  task automatic chk(string n, logic [95:0] act, logic [95:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h, expected %h", n, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("busy_a", 96'(busy_a), 96'(e.busy));
        chk("busy_b", 96'(busy_b), 96'(e.busy));
        chk("coll_a", 96'(coll_a), 96'(e.coll));
        chk("coll_b", 96'(coll_b), 96'(e.coll));
        chk("rd_dat_bypass", rd_a, e.rda);
        chk("rd_dat_nobypass", rd_b, e.rdb);
        chk("sweep_busy", 96'(s_busy), 96'(0));
        chk("sweep_coll", 96'(s_coll), 96'(0));
        chk("sweep_rd_dat", 96'(s_rd_dat), 96'(e.rds));
      end
    end
  end

  initial begin
    reset = 1'b1; rd_en = 4'h0; wr_en = 2'b00;
    rd_adr = 24'h0; wr_adr = 12'h0; wr_dat = 48'h0;
    @(negedge clk);
    step();
    repeat (64) begin rnd(); step(); end
    idle(); rd_en = 4'b0111; rd_adr = {6'd0, 6'd63, 6'd31, 6'd0}; step();
    step();
    wr_en = 2'b01; wr_adr = {6'd0, 6'd5}; wr_dat = {24'h0, 24'hABCDEF}; step();
    idle(); rd_en = 4'b0111; rd_adr = {4{6'd5}}; step();
    rd_en = 4'b1111; step();
    idle(); wr_en = 2'b11; wr_adr = {6'd5, 6'd5}; wr_dat = {24'h222222, 24'h111111}; step();
    idle(); rd_en = 4'b0001; step();
    idle(); wr_en = 2'b01; wr_adr = {6'd0, 6'd9}; wr_dat = {24'h0, 24'h000001}; step();
    wr_dat = {24'h0, 24'h0000FF}; rd_en = 4'b0001; rd_adr = {4{6'd9}}; step();
    idle(); rd_en = 4'b0010; step();
    repeat (300) begin rnd(); step(); end
    idle(); reset = 1'b1; step();
    repeat (20) begin rnd(); step(); end
    idle(); reset = 1'b1; step();
    repeat (64) begin rnd(); step(); end
    idle(); rd_en = 4'hF; rd_adr = {6'd63, 6'd5, 6'd9, 6'd0}; step();
    repeat (200) begin rnd(); step(); end
    idle(); step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
